// File: rtl/iir_tdm_ctrl.sv
// iir_tdm_ctrl
// Sequencer for a time-multiplexed 7-adaptor wave-digital IIR lattice.
// One shared 2-port adaptor is stepped through all seven adaptors of a
// sample, one per cycle, in a dependency-safe order.
//
// Build option: define IIR_TDM_COEF_LOAD_EN for loadable shadow/active
// coefficient banks. Without it the coefficients are fixed defaults and the
// coef_* inputs are ignored.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for sample_vld
// RUN   | one adaptor step per cycle, step_cnt 0..6
// DONE  | one cycle, out_vld high; a new sample may be accepted here
//
// Ports
//   clk, reset                 clock, async active-high reset
//   sample_vld, data_in        sample strobe and data
//   ovr_clr                    clears sticky overrun
//   coef_wr/addr/wdata/commit  shadow coefficient load and commit
//   data_hold                  latched sample for adaptors 1 and 4
//   busy, step_vld, step_id    sequencing status and current adaptor
//   alpha                      coefficient of current step
//   b_we, st_we                one-hot register-file write enables
//   out_vld                    final results of adaptors 2 and 6 ready
//   overrun                    sticky: sample arrived while busy
module iir_tdm_ctrl #(
    parameter int IN_WID = 10,
    parameter int CW     = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_vld,
    input  logic [IN_WID-1:0] data_in,
    input  logic              ovr_clr,
    input  logic              coef_wr,
    input  logic [2:0]        coef_addr,
    input  logic [CW-1:0]     coef_wdata,
    input  logic              coef_commit,
    output logic [IN_WID-1:0] data_hold,
    output logic              busy,
    output logic              step_vld,
    output logic [2:0]        step_id,
    output logic [CW-1:0]     alpha,
    output logic [6:0]        b_we,
    output logic [6:0]        st_we,
    output logic              out_vld,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [2:0] step_cnt;
    logic [2:0] next_id;
    logic       accept;

    // Adaptors 1,3,2,5,4,7,6: each port-a producer precedes its consumer.
    function automatic logic [2:0] step_order(input logic [2:0] cnt);
        case (cnt)
            3'd0:    step_order = 3'd0;
            3'd1:    step_order = 3'd2;
            3'd2:    step_order = 3'd1;
            3'd3:    step_order = 3'd4;
            3'd4:    step_order = 3'd3;
            3'd5:    step_order = 3'd6;
            3'd6:    step_order = 3'd5;
            default: step_order = 3'd0;
        endcase
    endfunction

    function automatic logic [CW-1:0] coef_default(input logic [2:0] idx);
        case (idx)
            3'd0:    coef_default = CW'(662);
            3'd1:    coef_default = CW'(12'h4E5);
            3'd2:    coef_default = CW'(740);
            3'd3:    coef_default = CW'(12'h5CC);
            3'd4:    coef_default = CW'(850);
            3'd5:    coef_default = CW'(12'h440);
            3'd6:    coef_default = CW'(691);
            default: coef_default = '0;
        endcase
    endfunction

    assign accept  = sample_vld && (state != RUN);
    assign next_id = step_order(step_cnt + 3'd1);

    // active_bank: coefficients of the sample in flight.
    // accept_bank: coefficients that the sample accepted this cycle will use.
    logic [CW-1:0] active_bank [7];
    logic [CW-1:0] accept_bank [7];

`ifdef IIR_TDM_COEF_LOAD_EN
    logic [CW-1:0] shadow_bank [7];
    logic [CW-1:0] shadow_next [7];
    logic          commit_pend;

    // Same-cycle write is visible to a same-cycle commit/accept.
    always_comb begin
        shadow_next = shadow_bank;
        if (coef_wr && (coef_addr != 3'd7))
            shadow_next[coef_addr] = coef_wdata;
    end

    always_comb begin
        if (commit_pend || coef_commit)
            accept_bank = shadow_next;
        else
            accept_bank = active_bank;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                shadow_bank[i] <= coef_default(3'(i));
                active_bank[i] <= coef_default(3'(i));
            end
            commit_pend <= 1'b0;
        end else begin
            shadow_bank <= shadow_next;
            if (accept) begin
                active_bank <= accept_bank;
                commit_pend <= 1'b0;
            end else if (coef_commit) begin
                commit_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_coef;
    assign unused_coef = ^{coef_wr, coef_addr, coef_wdata, coef_commit};

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            active_bank[i] = coef_default(3'(i));
            accept_bank[i] = coef_default(3'(i));
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            step_cnt  <= 3'd0;
            data_hold <= '0;
            busy      <= 1'b0;
            step_vld  <= 1'b0;
            step_id   <= 3'd0;
            alpha     <= '0;
            b_we      <= 7'd0;
            st_we     <= 7'd0;
            out_vld   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_vld <= 1'b0;

            if (sample_vld && (state == RUN))
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state     <= RUN;
                        step_cnt  <= 3'd0;
                        data_hold <= data_in;
                        busy      <= 1'b1;
                        step_vld  <= 1'b1;
                        step_id   <= step_order(3'd0);
                        alpha     <= accept_bank[step_order(3'd0)];
                        b_we      <= 7'd1 << step_order(3'd0);
                        st_we     <= 7'd1 << step_order(3'd0);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (step_cnt == 3'd6) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        step_vld <= 1'b0;
                        step_id  <= 3'd0;
                        alpha    <= '0;
                        b_we     <= 7'd0;
                        st_we    <= 7'd0;
                        out_vld  <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt + 3'd1;
                        step_id  <= next_id;
                        alpha    <= active_bank[next_id];
                        b_we     <= 7'd1 << next_id;
                        st_we    <= 7'd1 << next_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_tdm_ctrl.sv
module tb_iir_tdm_ctrl;
    localparam int IN_WID = 10;
    localparam int CW     = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_vld;
    logic [IN_WID-1:0] data_in;
    logic              ovr_clr;
    logic              coef_wr;
    logic [2:0]        coef_addr;
    logic [CW-1:0]     coef_wdata;
    logic              coef_commit;
    logic [IN_WID-1:0] data_hold;
    logic              busy;
    logic              step_vld;
    logic [2:0]        step_id;
    logic [CW-1:0]     alpha;
    logic [6:0]        b_we;
    logic [6:0]        st_we;
    logic              out_vld;
    logic              overrun;

    iir_tdm_ctrl #(.IN_WID(IN_WID), .CW(CW)) dut (
        .clk(clk), .reset(reset), .sample_vld(sample_vld), .data_in(data_in),
        .ovr_clr(ovr_clr), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .coef_commit(coef_commit),
        .data_hold(data_hold), .busy(busy), .step_vld(step_vld),
        .step_id(step_id), .alpha(alpha), .b_we(b_we), .st_we(st_we),
        .out_vld(out_vld), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_out;
        logic [2:0]        id;
        logic [CW-1:0]     alpha;
        logic [IN_WID-1:0] dh;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   out_cnt = 0;

    logic [2:0]    order   [7];
    logic [CW-1:0] m_active[7];
    logic [CW-1:0] m_shadow[7];
    bit            m_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_WID-1:0] d);
        exp_t e;
        if (m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        for (int k = 0; k < 7; k++) begin
            e.is_out = 1'b0;
            e.id     = order[k];
            e.alpha  = m_active[order[k]];
            e.dh     = d;
            q.push_back(e);
        end
        e.is_out = 1'b1;
        e.id     = 3'd0;
        e.alpha  = '0;
        e.dh     = d;
        q.push_back(e);
        sample_vld = 1'b1;
        data_in    = d;
        tick();
        sample_vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        check("drain_timeout", q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_hold"}, data_hold, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_step_vld"}, step_vld, 0);
        check({tag, "_step_id"}, step_id, 0);
        check({tag, "_alpha"}, alpha, 0);
        check({tag, "_b_we"}, b_we, 0);
        check({tag, "_st_we"}, st_we, 0);
        check({tag, "_out_vld"}, out_vld, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic model_reset();
        m_active[0] = 11'd662;  m_active[1] = 11'h4E5; m_active[2] = 11'd740;
        m_active[3] = 11'h5CC;  m_active[4] = 11'd850; m_active[5] = 11'h440;
        m_active[6] = 11'd691;
        m_shadow  = m_active;
        m_pending = 1'b0;
    endtask

    // Monitor: pops one expectation per step_vld or out_vld cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (step_vld || out_vld) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: step_vld=%0b out_vld=%0b with no expectation at %0t",
                             step_vld, out_vld, $time);
                end else begin
                    e = q.pop_front();
                    check("kind_out_vld", out_vld, e.is_out);
                    check("kind_step_vld", step_vld, !e.is_out);
                    check("data_hold", data_hold, e.dh);
                    if (!e.is_out) begin
                        check("step_id", step_id, e.id);
                        check("alpha", alpha, e.alpha);
                        check("b_we", b_we, 7'd1 << e.id);
                        check("st_we", st_we, 7'd1 << e.id);
                        check("busy_run", busy, 1);
                    end else begin
                        check("busy_done", busy, 0);
                        check("we_done", {b_we, st_we}, 0);
                        out_cnt++;
                    end
                end
            end else begin
                check("idle_alpha", alpha, 0);
                check("idle_we", {b_we, st_we}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        order[0] = 3'd0; order[1] = 3'd2; order[2] = 3'd1; order[3] = 3'd4;
        order[4] = 3'd3; order[5] = 3'd6; order[6] = 3'd5;
        model_reset();
        reset = 1'b1; sample_vld = 1'b0; data_in = '0; ovr_clr = 1'b0;
        coef_wr = 1'b0; coef_addr = 3'd0; coef_wdata = '0; coef_commit = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single sample, default coefficients
        send(10'h155);
        check("data_hold_T1", data_hold, 10'h155);
        check("alpha_T1", alpha, 11'd662);
        drain();
        check("out_cnt_single", out_cnt, 1);

        // 20 samples at the minimum 8-cycle period
        for (int i = 0; i < 20; i++) begin
            send(IN_WID'(i * 37 + 5));
            repeat (7) tick();
        end
        drain();
        check("overrun_periodic", overrun, 0);
        check("out_cnt_periodic", out_cnt, 21);

        // Strobe during RUN is dropped and flags overrun
        send(10'h2A5);
        repeat (3) tick();
        sample_vld = 1'b1; data_in = 10'h0F0;
        tick();
        sample_vld = 1'b0;
        check("overrun_set", overrun, 1);
        check("data_hold_kept", data_hold, 10'h2A5);
        drain();
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("overrun_clr", overrun, 0);
        send(10'h111);
        repeat (2) tick();
        sample_vld = 1'b1; ovr_clr = 1'b1; data_in = 10'h3FF;
        tick();
        sample_vld = 1'b0; ovr_clr = 1'b0;
        check("overrun_set_wins", overrun, 1);
        drain();
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("overrun_clr_alone", overrun, 0);

        // Reset in the middle of a sample
        send(10'h3C3);
        repeat (2) tick();
        reset = 1'b1;
        q.delete();
        #1;
        check_all_zero("midrun_reset");
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        check_all_zero("after_reset");
        out_cnt = 0;
        send(10'h0AB);
        drain();
        check("out_cnt_after_reset", out_cnt, 1);

`ifdef IIR_TDM_COEF_LOAD_EN
        // Commit during RUN applies only to the next sample
        send(10'h050);
        tick();
        coef_wr = 1'b1; coef_addr = 3'd2; coef_wdata = 11'h123;
        tick();
        coef_wr = 1'b0; coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        m_shadow[2] = 11'h123;
        m_pending   = 1'b1;
        coef_wr = 1'b1; coef_addr = 3'd7; coef_wdata = 11'h7FF;
        tick();
        coef_wr = 1'b0;
        drain();
        send(10'h060);
        drain();
        // Write, commit and accept in one cycle
        coef_wr = 1'b1; coef_addr = 3'd4; coef_wdata = 11'h2AA; coef_commit = 1'b1;
        m_shadow[4] = 11'h2AA;
        m_active    = m_shadow;
        send(10'h070);
        coef_wr = 1'b0; coef_commit = 1'b0;
        drain();
`else
        // Coefficient port has no effect in the fixed build
        coef_wr = 1'b1; coef_addr = 3'd2; coef_wdata = 11'h123; coef_commit = 1'b1;
        tick();
        coef_wr = 1'b0; coef_commit = 1'b0;
        send(10'h060);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iir_tdm_ctrl.md
# iir_tdm_ctrl

Sequencer for a time-multiplexed build of the 7-adaptor wave-digital IIR lattice. A single shared 2-port adaptor datapath evaluates all seven adaptors of one sample, one per cycle. This block accepts input sample strobes and latches the sample. It steps the shared adaptor through a dependency-safe order, drives the coefficient and register-file write enables for each step, signals output completion and flags overruns. It sits between the sample source and the shared adaptor/register-file datapath; it carries no filter arithmetic itself.

## Interface
- IN_WID, 10, input sample width
- CW, 11, coefficient (alpha) width

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sample_vld  in  1  one-cycle strobe; data_in valid
- data_in  in  IN_WID  input sample
- ovr_clr  in  1  clears sticky overrun flag
- coef_wr  in  1  shadow coefficient write (COEF_LOAD build only)
- coef_addr  in  3  shadow index 0..6; 7 ignored
- coef_wdata  in  CW  shadow write data
- coef_commit  in  1  request shadow→active copy at next accepted sample
- data_hold  out  IN_WID  latched sample fed to adaptors 1 and 4
- busy  out  1  high in RUN
- step_vld  out  1  shared adaptor evaluates this cycle
- step_id  out  3  adaptor index 0..6 (adaptor n+1)
- alpha  out  CW  coefficient for current step
- b_we  out  7  one-hot write enable, port-a result register of step_id
- st_we  out  7  one-hot write enable, port-b state register of step_id
- out_vld  out  1  one-cycle pulse: port-a results of adaptors 2 and 6 final, output combine may sample
- overrun  out  1  sticky: sample_vld arrived while busy

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Accept: sample_vld in IDLE or DONE → data_hold <= data_in, step_cnt <= 0, go RUN.
- RUN: step_vld=1; step order by step_cnt 0..6 = adaptors 1,3,2,5,4,7,6 (step_id 0,2,1,4,3,6,5). Every adaptor's port-a dependency is produced before its consumer, so adaptors 2, 4 and 6 read results that are registered the same sample.
- b_we[step_id]=st_we[step_id]=1 only while step_vld; else 0.
- alpha = active_coef[step_id] during RUN; 0 otherwise.
- step_cnt==6 → DONE. DONE lasts one cycle, out_vld=1, then IDLE unless a new sample is accepted.
- sample_vld in RUN: sample dropped, data_hold unchanged, overrun <= 1. Set wins over simultaneous ovr_clr.
- Reset mid-RUN: immediate IDLE, all outputs to reset values, partial sample discarded; the datapath state registers are not cleared by this block.
- Reset values: data_hold 0, busy 0, step_vld 0, step_id 0, alpha 0, b_we 0, st_we 0, out_vld 0, overrun 0.

## Timing
- Accept at cycle T: data_hold valid T+1; steps at T+1..T+7; out_vld at T+8.
- Minimum sample period 8 cycles, because back-to-back acceptance in DONE is allowed.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- IIR_TDM_COEF_LOAD_EN defined: 7×CW shadow and active coefficient banks.
  - coef_wr writes shadow[coef_addr]; addr 7 ignored.
  - coef_commit sets a pending flag; the active bank is copied from shadow on the next sample acceptance, never mid-sample.
  - If commit and accept occur in the same cycle, the new coefficients apply to that sample. A write and commit in the same cycle include that write.
  - Reset loads both banks with the defaults.
- Undefined: active bank hard-wired to defaults 662, 0x4E5, 740, 0x5CC, 850, 0x440, 691 (index 0..6); coef_* inputs ignored.

## Test plan
- Reset, one sample_vld with data_in=0x155 → data_hold=0x155 at T+1; step_id 0,2,1,4,3,6,5 on T+1..T+7 with one-hot b_we/st_we; alpha sequence 662,740,0x4E5,850,0x5CC,691,0x440; out_vld only at T+8.
- Strobes every 8 cycles for 20 samples → no overrun, 20 out_vld pulses, gapless steps.
- sample_vld at T+4 → ignored, data_hold unchanged, overrun=1. ovr_clr together with a new overrun → overrun stays 1; ovr_clr alone → 0.
- Reset asserted at T+3 → all outputs 0 next cycle, IDLE. A fresh sample afterwards runs a full normal sequence.
- (COEF_LOAD) write addr 2=0x123, commit during RUN → current sample still uses 740; next sample step_id 2 alpha=0x123. Write to addr 7 → no bank change.
- (COEF_LOAD) commit and accept in the same cycle → new coefficient used by that sample.
